// File: rtl/cp0_pkg.sv
// ---------------------------------------------------------------------------
// cp0_pkg -- shared CP0 definitions.
//   * ExcCode values written into Cause.ExcCode
//   * State encoding of the exception/flush sequencer
//   * Default exception vector (redirect target on any exception)
// ---------------------------------------------------------------------------
package cp0_pkg;

    // Cause.ExcCode values
    localparam int unsigned EXC_INT  = 0;   // interrupt
    localparam int unsigned EXC_ADEL = 4;   // address error, load / fetch
    localparam int unsigned EXC_ADES = 5;   // address error, store
    localparam int unsigned EXC_SYS  = 8;   // syscall
    localparam int unsigned EXC_BP   = 9;   // breakpoint
    localparam int unsigned EXC_RI   = 10;  // reserved instruction
    localparam int unsigned EXC_OV   = 12;  // arithmetic overflow

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // RUN: normal flow. REDIR: a redirect was issued at the last edge.
    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } exc_state_e;

endpackage : cp0_pkg

// File: rtl/exc_prio_enc.sv
// ---------------------------------------------------------------------------
// exc_prio_enc -- oldest-first priority encoder.
// The highest set request index wins (highest index = oldest stage).
//
// Ports:
//   req    in  N      request vector
//   valid  out 1      at least one request is set
//   idx    out IDX_W  index of the winning request (0 when none)
//   onehot out N      one-hot of the winning request (0 when none)
// ---------------------------------------------------------------------------
module exc_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        // Ascending scan: a later (older) hit overrides an earlier one.
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        onehot[idx] = valid;
    end

endmodule : exc_prio_enc

// File: rtl/exc_flush_ctrl.sv
// ---------------------------------------------------------------------------
// exc_flush_ctrl -- exception priority and pipeline flush controller.
// Arbitrates per-stage exception requests (oldest stage wins), drives the
// per-stage flush vector, owns EPC / Cause.ExcCode / Cause.BD / Status.EXL,
// sequences ERET and issues a registered PC redirect to fetch.
//
// Optional feature macro: EXC_INT_EN -- adds int_req/int_mask; a masked,
// pending interrupt with EXL clear behaves as an ExcCode 0 exception at the
// oldest stage, ranking below a real exception there.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   exc_detect      per-stage exception request
//   exc_cause       per-stage ExcCode, slice i = stage i
//   stage_pc        per-stage PC, slice i = stage i
//   stage_bd        per-stage branch-delay-slot flag
//   eret, id_stall  ERET decoded in ID, ID stalled
//   flush           per-stage flush (combinational)
//   exc_taken       pulse: exception committed
//   redirect_valid  pulse: fetch must load redirect_pc
//   redirect_pc     redirect target
//   epc, cause_code, cause_bd, exl   CP0 registers
//   int_req, int_mask (EXC_INT_EN only)  interrupt lines and enables
// ---------------------------------------------------------------------------
module exc_flush_ctrl
    import cp0_pkg::*;
#(
    parameter int              NUM_STAGES = 4,
    parameter int              XLEN       = 32,
    parameter int              CAUSE_W    = 5,
    parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(EXC_VECTOR_DEFAULT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_STAGES-1:0]         exc_detect,
    input  logic [NUM_STAGES*CAUSE_W-1:0] exc_cause,
    input  logic [NUM_STAGES*XLEN-1:0]    stage_pc,
    input  logic [NUM_STAGES-1:0]         stage_bd,
    input  logic                          eret,
    input  logic                          id_stall,
    output logic [NUM_STAGES-1:0]         flush,
    output logic                          exc_taken,
    output logic                          redirect_valid,
    output logic [XLEN-1:0]               redirect_pc,
    output logic [XLEN-1:0]               epc,
    output logic [CAUSE_W-1:0]            cause_code,
    output logic                          cause_bd,
    output logic                          exl
`ifdef EXC_INT_EN
    ,
    input  logic [5:0]                    int_req,
    input  logic [5:0]                    int_mask
`endif
);

    localparam int IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int OLDEST = NUM_STAGES - 1;

    exc_state_e        state_q, state_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic [CAUSE_W-1:0] cause_code_q, cause_code_d;
    logic              cause_bd_q, cause_bd_d;
    logic              exl_q, exl_d;
    logic              exc_taken_q, exc_taken_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic              reset_r_q;

    logic [NUM_STAGES-1:0] req_vec;
    logic                  win_valid;
    logic [IDX_W-1:0]      win_idx;
    logic [NUM_STAGES-1:0] win_onehot;
    logic [CAUSE_W-1:0]    win_cause;
    logic [XLEN-1:0]       win_pc;
    logic                  win_bd;
    logic                  eret_go;
    logic                  take_eret;

`ifdef EXC_INT_EN
    logic int_pending;
    assign int_pending = (|(int_req & int_mask)) & ~exl_q;

    always_comb begin
        req_vec         = exc_detect;
        req_vec[OLDEST] = exc_detect[OLDEST] | int_pending;
    end
`else
    assign req_vec = exc_detect;
`endif

    exc_prio_enc #(
        .N     (NUM_STAGES),
        .IDX_W (IDX_W)
    ) u_prio (
        .req    (req_vec),
        .valid  (win_valid),
        .idx    (win_idx),
        .onehot (win_onehot)
    );

    // Winner's cause / PC / delay-slot flag.
    always_comb begin
        win_cause = exc_cause[win_idx*CAUSE_W +: CAUSE_W];
        win_pc    = stage_pc[win_idx*XLEN +: XLEN];
        win_bd    = stage_bd[win_idx];
`ifdef EXC_INT_EN
        // Winner came from the interrupt line, not a real stage exception.
        if (!exc_detect[win_idx]) begin
            win_cause = CAUSE_W'(EXC_INT);
        end
`endif
    end

    // flush[i] = any request at stage i or older. Because the winner is the
    // oldest request, that equals "winner index >= i".
    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int i = OLDEST; i >= 0; i--) begin
            acc      = acc | win_onehot[i];
            flush[i] = acc;
        end
        flush[0] = flush[0] | eret_go | reset_r_q;
    end

    assign eret_go   = eret & ~id_stall;
    // An exception in the same cycle wins; ERET seen during REDIR is dropped.
    assign take_eret = eret_go & ~win_valid & (state_q == RUN);

    always_comb begin
        state_d          = RUN;
        epc_d            = epc_q;
        redirect_pc_d    = redirect_pc_q;
        cause_code_d     = cause_code_q;
        cause_bd_d       = cause_bd_q;
        exl_d            = exl_q;
        exc_taken_d      = 1'b0;
        redirect_valid_d = 1'b0;

        if (win_valid) begin
            state_d          = REDIR;
            exc_taken_d      = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = EXC_VECTOR;
            cause_code_d     = win_cause;
            // Nested exception keeps the original return point.
            if (!exl_q) begin
                epc_d      = win_bd ? (win_pc - XLEN'(4)) : win_pc;
                cause_bd_d = win_bd;
                exl_d      = 1'b1;
            end
        end else if (take_eret) begin
            state_d          = REDIR;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = epc_q;
            exl_d            = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            epc_q            <= '0;
            redirect_pc_q    <= EXC_VECTOR;
            cause_code_q     <= '0;
            cause_bd_q       <= 1'b0;
            exl_q            <= 1'b1;
            exc_taken_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            reset_r_q        <= 1'b1;
        end else begin
            state_q          <= state_d;
            epc_q            <= epc_d;
            redirect_pc_q    <= redirect_pc_d;
            cause_code_q     <= cause_code_d;
            cause_bd_q       <= cause_bd_d;
            exl_q            <= exl_d;
            exc_taken_q      <= exc_taken_d;
            redirect_valid_q <= redirect_valid_d;
            reset_r_q        <= 1'b0;
        end
    end

    assign epc            = epc_q;
    assign redirect_pc    = redirect_pc_q;
    assign cause_code     = cause_code_q;
    assign cause_bd       = cause_bd_q;
    assign exl            = exl_q;
    assign exc_taken      = exc_taken_q;
    assign redirect_valid = redirect_valid_q;

endmodule : exc_flush_ctrl

// File: tb/tb_exc_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_flush_ctrl -- directed bench for exc_flush_ctrl (default build).
// Inputs change just after a falling edge; the combinational flush is read
// 1 ns later and registered outputs are read at the next falling edge.
// ---------------------------------------------------------------------------
module tb_exc_flush_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic         clk;
    logic         rst_n;
    logic [3:0]   exc_detect;
    logic [19:0]  exc_cause;
    logic [127:0] stage_pc;
    logic [3:0]   stage_bd;
    logic         eret;
    logic         id_stall;
    logic [3:0]   flush;
    logic         exc_taken;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [31:0]  epc;
    logic [4:0]   cause_code;
    logic         cause_bd;
    logic         exl;

    int n_vec = 0;
    int n_err = 0;

    exc_flush_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exc_detect     (exc_detect),
        .exc_cause      (exc_cause),
        .stage_pc       (stage_pc),
        .stage_bd       (stage_bd),
        .eret           (eret),
        .id_stall       (id_stall),
        .flush          (flush),
        .exc_taken      (exc_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .epc            (epc),
        .cause_code     (cause_code),
        .cause_bd       (cause_bd),
        .exl            (exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        exc_detect = '0;
        exc_cause  = '0;
        stage_pc   = '0;
        stage_bd   = '0;
        eret       = 1'b0;
        id_stall   = 1'b0;
    endtask

    task automatic set_exc(input int s, input logic [4:0] c, input logic [31:0] pc, input logic bd);
        exc_detect[s]        = 1'b1;
        exc_cause[s*5 +: 5]  = c;
        stage_pc[s*32 +: 32] = pc;
        stage_bd[s]          = bd;
    endtask

    // Unstalled ERET from RUN; leaves the DUT back in RUN with exl=0.
    task automatic eret_release(input logic [31:0] exp_pc);
        eret = 1'b1;
        #1 check("eret_flush", 32'(flush), 32'h1);
        @(negedge clk);
        eret = 1'b0;
        check("eret_rv", 32'(redirect_valid), 32'h1);
        check("eret_taken", 32'(exc_taken), 32'h0);
        check("eret_exl", 32'(exl), 32'h0);
        check("eret_rpc", redirect_pc, exp_pc);
        @(negedge clk);
        check("eret_rv_drop", 32'(redirect_valid), 32'h0);
    endtask

    initial begin
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_flush", 32'(flush), 32'h1);
        check("rst_exl", 32'(exl), 32'h1);
        check("rst_epc", epc, 32'h0);
        check("rst_rpc", redirect_pc, VEC);
        check("rst_rv", 32'(redirect_valid), 32'h0);
        check("rst_taken", 32'(exc_taken), 32'h0);
        check("rst_cause", 32'(cause_code), 32'h0);
        check("rst_bd", 32'(cause_bd), 32'h0);

        // Release: flush[0] only for the first cycle
        rst_n = 1'b1;
        #1 check("rel_flush_first", 32'(flush), 32'h1);
        @(negedge clk);
        check("rel_flush_second", 32'(flush), 32'h0);
        check("rel_exl", 32'(exl), 32'h1);
        check("rel_rv", 32'(redirect_valid), 32'h0);

        eret_release(32'h0);

        // Two stages at once, exl=0: stage 2 wins
        set_exc(2, 5'd12, 32'h100, 1'b0);
        set_exc(1, 5'd4, 32'h104, 1'b0);
        #1 check("t2_flush", 32'(flush), 32'h7);
        @(negedge clk);
        clear_in();
        check("t2_epc", epc, 32'h100);
        check("t2_cause", 32'(cause_code), 32'd12);
        check("t2_bd", 32'(cause_bd), 32'h0);
        check("t2_exl", 32'(exl), 32'h1);
        check("t2_rpc", redirect_pc, VEC);
        check("t2_taken", 32'(exc_taken), 32'h1);
        check("t2_rv", 32'(redirect_valid), 32'h1);
        @(negedge clk);
        check("t2_rv_drop", 32'(redirect_valid), 32'h0);
        check("t2_taken_drop", 32'(exc_taken), 32'h0);

        eret_release(32'h100);

        // Delay-slot exception at oldest stage
        set_exc(3, 5'd5, 32'h204, 1'b1);
        #1 check("t3_flush", 32'(flush), 32'hF);
        @(negedge clk);
        clear_in();
        check("t3_epc", epc, 32'h200);
        check("t3_bd", 32'(cause_bd), 32'h1);
        check("t3_cause", 32'(cause_code), 32'd5);
        check("t3_exl", 32'(exl), 32'h1);

        // Nested, back-to-back from REDIR: only cause_code moves
        set_exc(1, 5'd10, 32'h300, 1'b0);
        #1 check("t4_flush", 32'(flush), 32'h3);
        @(negedge clk);
        clear_in();
        check("t4_epc", epc, 32'h200);
        check("t4_bd", 32'(cause_bd), 32'h1);
        check("t4_cause", 32'(cause_code), 32'd10);
        check("t4_rv", 32'(redirect_valid), 32'h1);
        check("t4_taken", 32'(exc_taken), 32'h1);
        @(negedge clk);
        check("t4_rv_drop", 32'(redirect_valid), 32'h0);

        // Prepare epc=0x400 with exl=1
        eret_release(32'h200);
        set_exc(2, 5'd8, 32'h400, 1'b0);
        @(negedge clk);
        clear_in();
        check("t5_epc", epc, 32'h400);
        check("t5_exl", 32'(exl), 32'h1);
        @(negedge clk);

        // Stalled ERET is held off
        eret = 1'b1;
        id_stall = 1'b1;
        #1 check("t5_stall_flush0", 32'(flush), 32'h0);
        @(negedge clk);
        check("t5_stall_flush1", 32'(flush), 32'h0);
        check("t5_stall_rv1", 32'(redirect_valid), 32'h0);
        check("t5_stall_exl1", 32'(exl), 32'h1);
        @(negedge clk);
        check("t5_stall_rv2", 32'(redirect_valid), 32'h0);
        check("t5_stall_exl2", 32'(exl), 32'h1);
        id_stall = 1'b0;
        #1 check("t5_go_flush", 32'(flush), 32'h1);
        @(negedge clk);
        check("t5_rpc", redirect_pc, 32'h400);
        check("t5_exl_clr", 32'(exl), 32'h0);
        check("t5_taken", 32'(exc_taken), 32'h0);
        check("t5_rv", 32'(redirect_valid), 32'h1);
        // eret still high while in REDIR: ignored
        @(negedge clk);
        eret = 1'b0;
        check("t5_redir_eret_rv", 32'(redirect_valid), 32'h0);
        check("t5_redir_eret_exl", 32'(exl), 32'h0);

        // Exception and ERET in the same cycle: exception wins
        eret = 1'b1;
        set_exc(3, 5'd12, 32'h500, 1'b0);
        #1 check("t6_flush", 32'(flush), 32'hF);
        @(negedge clk);
        clear_in();
        check("t6_exl", 32'(exl), 32'h1);
        check("t6_rpc", redirect_pc, VEC);
        check("t6_taken", 32'(exc_taken), 32'h1);
        check("t6_epc", epc, 32'h500);

        // Reset while in REDIR aborts the redirect
        rst_n = 1'b0;
        #1;
        check("t7_rv", 32'(redirect_valid), 32'h0);
        check("t7_taken", 32'(exc_taken), 32'h0);
        check("t7_exl", 32'(exl), 32'h1);
        check("t7_epc", epc, 32'h0);
        check("t7_cause", 32'(cause_code), 32'h0);
        check("t7_rpc", redirect_pc, VEC);
        check("t7_flush", 32'(flush), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Delay slot at PC 0: EPC wraps
        eret_release(32'h0);
        set_exc(3, 5'd9, 32'h0, 1'b1);
        @(negedge clk);
        clear_in();
        check("t8_epc_wrap", epc, 32'hFFFF_FFFC);
        check("t8_bd", 32'(cause_bd), 32'h1);
        check("t8_cause", 32'(cause_code), 32'd9);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_exc_flush_ctrl
